mimo_input_packer: RTL and testbench
====================================

# mimo_input_packer

Upstream framing stage for the 4x4 sphere-decoding MIMO detector. Accepts a stream of complex elements, one per cycle, and packs them into 4-element vectors. Emits each vector on the detector's wide input port together with the channel/data flag. Also enforces the load order the detector needs: 4 channel rows, then any number of received vectors, with a new channel allowed at any vector boundary.

## Interface
Parameters:
- WIDTH, 16, bits per real or imaginary component (6 integer bits including sign, 10 fractional bits).

Ports:
- Clk  input  1  clock. One clock domain.
- Reset  input  1  reset. Synchronous, active-high.
- i_valid  input  1  upstream element valid.
- o_ready  output  1  upstream ready. An element transfers when i_valid && o_ready.
- i_is_channel  input  1  1 = element belongs to a channel row; 0 = element belongs to a received vector.
- i_elem  input  2*WIDTH  complex element: real part in [2*WIDTH-1:WIDTH], imaginary part in [WIDTH-1:0].
- o_out_valid  output  1  packed vector valid.
- i_out_ready  input  1  downstream ready; connects to the detector's o_in_ready. A vector transfers when o_out_valid && i_out_ready.
- o_flag  output  1  channel/data flag of the vector; drives the detector's flagChannelorData.
- o_out_data  output  8*WIDTH  packed vector. Element 0 (first arrival) is in [8*WIDTH-1 -: 2*WIDTH], element 3 is in [2*WIDTH-1:0].
- o_ch_loaded  output  1  a complete 4-row channel has been forwarded.
- o_err  output  1  sticky protocol error.

## Operation
- Assembly register with a 2-bit element counter `ecnt`.
  - Elements shift in MSB-first.
  - The kind bit is latched from element 0.
  - When element 3 is accepted, the assembled vector moves to the output register, and `ecnt` wraps to 0.
- Output register holds one vector. It is cleared on a downstream transfer.
- The output register is loaded only when it is empty or being drained in the same cycle.
- o_ready = !Reset && !(ecnt==3 && o_out_valid). This rule is conservative and has no combinational path from i_out_ready.
- FSM, tracking vectors as they leave assembly:
  - NEED_CH: after reset, no channel loaded yet. A completed channel vector goes to CH with row count 1.
  - CH: row counter 1..3. Channel vectors advance the counter. The 4th row goes to DATA and sets o_ch_loaded.
  - DATA: data vectors are forwarded. A channel vector starts a new group: go to CH with row count 1, clear o_ch_loaded.
- Protocol errors (checked only when the macro is defined). Each sets o_err, which stays set until Reset:
  - i_is_channel differs from the latched kind while ecnt != 0: the partial vector is discarded, and the offending element becomes element 0 of a new vector.
  - A data vector completes in NEED_CH or CH: the vector is dropped and the state is unchanged.
- Element data passes through unmodified. The block does no arithmetic.

## Timing
- Reset values: o_out_valid=0, o_flag=0, o_out_data=0, o_ch_loaded=0, o_err=0, ecnt=0, state NEED_CH.
- o_ready is low while Reset is high.
- Reset mid-vector discards all partial state.
- Latency: if element 3 is accepted at edge t, o_out_valid=1 from t+1.
- o_out_data and o_flag are stable while o_out_valid && !i_out_ready.
- Throughput: one vector per 4 cycles, with no bubbles when i_out_ready stays high.
- If the output register is full and ecnt==3, the 4th element stalls until the cycle after the downstream transfer.
- A downstream transfer and an element-3 acceptance in the same cycle: o_out_valid stays 1 and the new vector is presented.

## Configuration
- MIMO_PACKER_PROTO_CHECK_EN:
  - Defined: the kind-mismatch and ordering checks above are active.
  - Undefined: every completed vector is forwarded with its latched kind, the FSM only drives o_ch_loaded, o_err is tied 0, and a kind change mid-vector is ignored (kind stays as latched at element 0).

## Test plan
- Channel load: after reset, stream 16 channel elements with value k in both halves (k = 1..16), i_out_ready=1.
  - Expect 4 vectors with o_flag=1; vector 0 has [127:96]=0x0001_0001 and [31:0]=0x0004_0004.
  - o_ch_loaded=1 after the 4th transfer.
- Data after channel: 4 data elements follow the channel load.
  - Expect one vector with o_flag=0, o_out_valid 1 cycle after element 3.
- Backpressure: hold i_out_ready=0 and offer 8 elements.
  - Elements 1-7 accepted, o_ready=0 at ecnt==3.
  - Raising i_out_ready accepts element 8 the following cycle; both vectors are delivered in order.
- Data before channel, macro defined: 4 data elements after reset.
  - o_out_valid stays 0, o_err=1.
  - A following 16-element channel load is still forwarded.
- Kind switch and reset: 2 channel elements, then 1 data element.
  - o_err=1 and the new vector starts from the data element.
  - Then Reset for 1 cycle followed by 4 fresh elements: the vector contains only the fresh elements and o_err=0.
- Macro undefined: 4 data elements after reset.
  - Vector forwarded with o_flag=0, o_err=0.

Source files
------------

// File: rtl/mimo_input_packer.sv
// Packs one complex element per cycle into 4-element vectors for the MIMO detector and enforces channel-then-data load order.
// Optional protocol checking is enabled by defining MIMO_PACKER_PROTO_CHECK_EN.
module mimo_input_packer #(
   parameter int WIDTH = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic                 i_is_channel,
   input  logic [2*WIDTH-1:0]   i_elem,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic                 o_flag,
   output logic [8*WIDTH-1:0]   o_out_data,
   output logic                 o_ch_loaded,
   output logic                 o_err
);

`ifdef MIMO_PACKER_PROTO_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   localparam int EW = 2*WIDTH;

   typedef enum logic [1:0] {
      NEED_CH = 2'd0,
      CH      = 2'd1,
      DATA    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        ecnt_q, ecnt_d;
   logic [1:0]        row_q, row_d;
   logic [3*EW-1:0]   asm_q, asm_d;
   logic              kind_q, kind_d;
   logic              out_valid_q, out_valid_d;
   logic              out_flag_q, out_flag_d;
   logic [4*EW-1:0]   out_data_q, out_data_d;
   logic              ch_loaded_q, ch_loaded_d;
   logic              err_q, err_d;

   logic              accept;
   logic              drain;
   logic              mismatch;
   logic              complete;
   logic              drop;
   logic [4*EW-1:0]   vec;

   // Stalling element 3 whenever the output holds a vector keeps i_out_ready out of o_ready.
   assign o_ready  = !Reset && !(ecnt_q == 2'd3 && out_valid_q);
   assign accept   = i_valid && o_ready;
   assign drain    = out_valid_q && i_out_ready;
   assign mismatch = CHECK_EN && accept && (ecnt_q != 2'd0) && (i_is_channel != kind_q);
   assign vec      = {asm_q, i_elem};
   assign complete = accept && !mismatch && (ecnt_q == 2'd3);
   assign drop     = CHECK_EN && complete && !kind_q && (state_q != DATA);

   always_comb begin
      state_d     = state_q;
      ecnt_d      = ecnt_q;
      row_d       = row_q;
      asm_d       = asm_q;
      kind_d      = kind_q;
      out_valid_d = out_valid_q;
      out_flag_d  = out_flag_q;
      out_data_d  = out_data_q;
      ch_loaded_d = ch_loaded_q;
      err_d       = err_q;

      if (drain) begin
         out_valid_d = 1'b0;
         out_flag_d  = 1'b0;
         out_data_d  = '0;
      end

      if (accept) begin
         asm_d = {asm_q[2*EW-1:0], i_elem};
         if (mismatch) begin
            err_d  = 1'b1;
            kind_d = i_is_channel;
            ecnt_d = 2'd1;
         end else begin
            if (ecnt_q == 2'd0) begin
               kind_d = i_is_channel;
            end
            ecnt_d = ecnt_q + 2'd1;
         end
      end

      // The FSM only sees vectors that actually leave assembly.
      if (complete) begin
         if (drop) begin
            err_d = 1'b1;
         end else begin
            out_valid_d = 1'b1;
            out_flag_d  = kind_q;
            out_data_d  = vec;
            if (kind_q) begin
               case (state_q)
                  NEED_CH: begin
                     state_d = CH;
                     row_d   = 2'd1;
                  end
                  CH: begin
                     if (row_q == 2'd3) begin
                        state_d     = DATA;
                        row_d       = 2'd0;
                        ch_loaded_d = 1'b1;
                     end else begin
                        row_d = row_q + 2'd1;
                     end
                  end
                  DATA: begin
                     state_d     = CH;
                     row_d       = 2'd1;
                     ch_loaded_d = 1'b0;
                  end
                  default: begin
                     state_d = NEED_CH;
                     row_d   = 2'd0;
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= NEED_CH;
         ecnt_q      <= 2'd0;
         row_q       <= 2'd0;
         asm_q       <= '0;
         kind_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_flag_q  <= 1'b0;
         out_data_q  <= '0;
         ch_loaded_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ecnt_q      <= ecnt_d;
         row_q       <= row_d;
         asm_q       <= asm_d;
         kind_q      <= kind_d;
         out_valid_q <= out_valid_d;
         out_flag_q  <= out_flag_d;
         out_data_q  <= out_data_d;
         ch_loaded_q <= ch_loaded_d;
         err_q       <= err_d;
      end
   end

   assign o_out_valid = out_valid_q;
   assign o_flag      = out_flag_q;
   assign o_out_data  = out_data_q;
   assign o_ch_loaded = ch_loaded_q;
   assign o_err       = CHECK_EN ? err_q : 1'b0;

endmodule

// File: tb/tb_mimo_input_packer.sv
// Testbench for mimo_input_packer: directed load-order scenarios plus random traffic against a queue-based reference model.
module tb_mimo_input_packer;

   localparam int WIDTH = 16;
   localparam int EW    = 2*WIDTH;
   localparam int VW    = 8*WIDTH;

`ifdef MIMO_PACKER_PROTO_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic           Clk = 1'b0;
   logic           Reset;
   logic           i_valid;
   logic           o_ready;
   logic           i_is_channel;
   logic [EW-1:0]  i_elem;
   logic           o_out_valid;
   logic           i_out_ready;
   logic           o_flag;
   logic [VW-1:0]  o_out_data;
   logic           o_ch_loaded;
   logic           o_err;

   always #5 Clk = ~Clk;

   mimo_input_packer #(.WIDTH(WIDTH)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_is_channel (i_is_channel),
      .i_elem       (i_elem),
      .o_out_valid  (o_out_valid),
      .i_out_ready  (i_out_ready),
      .o_flag       (o_flag),
      .o_out_data   (o_out_data),
      .o_ch_loaded  (o_ch_loaded),
      .o_err        (o_err)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: pending elements, channel rows seen (4 = full channel), one output slot.
   logic [EW-1:0] m_part[$];
   logic          m_kind;
   int            m_rows;
   logic          m_valid;
   logic          m_flag;
   logic [VW-1:0] m_data;
   logic          m_err;
   logic          m_loaded;
   logic [VW:0]   got[$];

   task automatic checkOutput(input string tag, input logic [VW-1:0] observed, input logic [VW-1:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      m_part.delete();
      m_kind   = 1'b0;
      m_rows   = 0;
      m_valid  = 1'b0;
      m_flag   = 1'b0;
      m_data   = '0;
      m_err    = 1'b0;
      m_loaded = 1'b0;
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
   task automatic applyStimulus(input logic rst, input logic vld, input logic is_ch,
                                input logic [EW-1:0] elem, input logic ordy, output logic acc);
      logic          exp_ready;
      logic          drain;
      logic [VW-1:0] vec;
      Reset        = rst;
      i_valid      = vld;
      i_is_channel = is_ch;
      i_elem       = elem;
      i_out_ready  = ordy;
      #1;
      exp_ready = !rst && !(m_part.size() == 3 && m_valid);
      checkOutput("o_ready", VW'(o_ready), VW'(exp_ready));
      checkOutput("o_out_valid", VW'(o_out_valid), VW'(m_valid));
      checkOutput("o_ch_loaded", VW'(o_ch_loaded), VW'(m_loaded));
      checkOutput("o_err", VW'(o_err), VW'(m_err));
      if (m_valid) begin
         checkOutput("o_flag", VW'(o_flag), VW'(m_flag));
         checkOutput("o_out_data", o_out_data, m_data);
      end
      drain = m_valid && ordy;
      if (drain) got.push_back({o_flag, o_out_data});
      acc = vld && exp_ready;
      @(posedge Clk);
      if (rst) begin
         modelReset();
      end else begin
         if (drain) m_valid = 1'b0;
         if (acc) begin
            if (CHECK_EN && m_part.size() != 0 && is_ch != m_kind) begin
               m_err = 1'b1;
               m_part.delete();
            end
            if (m_part.size() == 0) m_kind = is_ch;
            m_part.push_back(elem);
            if (m_part.size() == 4) begin
               vec = {m_part[0], m_part[1], m_part[2], m_part[3]};
               m_part.delete();
               if (CHECK_EN && !m_kind && m_rows != 4) begin
                  m_err = 1'b1;
               end else begin
                  m_valid = 1'b1;
                  m_flag  = m_kind;
                  m_data  = vec;
                  if (m_kind) m_rows = (m_rows == 4) ? 1 : m_rows + 1;
                  m_loaded = (m_rows == 4);
               end
            end
         end
      end
      @(negedge Clk);
   endtask

   task automatic sendElem(input logic is_ch, input logic [EW-1:0] elem, input logic ordy);
      logic acc;
      acc = 1'b0;
      for (int n = 0; n < 40 && !acc; n++) applyStimulus(1'b0, 1'b1, is_ch, elem, ordy, acc);
      if (!acc) checkOutput("accept_timeout", VW'(0), VW'(1));
   endtask

   task automatic idle(input int n, input logic ordy);
      logic acc;
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, '0, ordy, acc);
   endtask

   task automatic doReset(input int n);
      logic acc;
      for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, acc);
   endtask

   task automatic channelLoad();
      for (int k = 1; k <= 16; k++) sendElem(1'b1, {16'(k), 16'(k)}, 1'b1);
      idle(2, 1'b1);
   endtask

   logic          acc_r;
   logic          kind_r;
   logic [VW-1:0] vec0;
   logic [VW-1:0] bp1;
   logic [VW-1:0] bp2;

   initial begin
      modelReset();
      Reset = 1'b1; i_valid = 1'b0; i_is_channel = 1'b0; i_elem = '0; i_out_ready = 1'b0;
      @(negedge Clk);
      doReset(3);
      checkOutput("reset_data", o_out_data, '0);
      checkOutput("reset_valid", VW'(o_out_valid), VW'(0));

      // Channel load of 16 rows of value k.
      got.delete();
      channelLoad();
      vec0 = 128'h0001_0001_0002_0002_0003_0003_0004_0004;
      checkOutput("ch_count", VW'(got.size()), VW'(4));
      if (got.size() >= 1) checkOutput("ch_vec0", got[0][VW-1:0], vec0);
      if (got.size() >= 1) checkOutput("ch_flag0", VW'(got[0][VW]), VW'(1));
      checkOutput("ch_loaded", VW'(o_ch_loaded), VW'(1));

      // Data vector after the channel.
      got.delete();
      for (int k = 0; k < 4; k++) sendElem(1'b0, 32'hA000_0000 + 32'(k), 1'b1);
      checkOutput("data_latency", VW'(o_out_valid), VW'(1));
      idle(2, 1'b1);
      checkOutput("data_count", VW'(got.size()), VW'(1));
      if (got.size() >= 1) checkOutput("data_flag", VW'(got[0][VW]), VW'(0));

      // Backpressure: 7 elements accepted with downstream stalled, the 8th waits.
      got.delete();
      for (int k = 1; k <= 7; k++) sendElem(1'b0, 32'hB000_0000 + 32'(k), 1'b0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'hB000_0008, 1'b0, acc_r);
      checkOutput("bp_ready_low", VW'(o_ready), VW'(0));
      applyStimulus(1'b0, 1'b1, 1'b0, 32'hB000_0008, 1'b1, acc_r);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'hB000_0008, 1'b1, acc_r);
      checkOutput("bp_accept_next", VW'(acc_r), VW'(1));
      idle(2, 1'b1);
      bp1 = 128'hB000_0001_B000_0002_B000_0003_B000_0004;
      bp2 = 128'hB000_0005_B000_0006_B000_0007_B000_0008;
      checkOutput("bp_count", VW'(got.size()), VW'(2));
      if (got.size() >= 2) begin
         checkOutput("bp_vec1", got[0][VW-1:0], bp1);
         checkOutput("bp_vec2", got[1][VW-1:0], bp2);
      end

      // Data straight after reset.
      doReset(1);
      got.delete();
      for (int k = 0; k < 4; k++) sendElem(1'b0, 32'hC000_0000 + 32'(k), 1'b1);
      idle(2, 1'b1);
      if (CHECK_EN) begin
         checkOutput("early_data_dropped", VW'(got.size()), VW'(0));
         checkOutput("early_data_err", VW'(o_err), VW'(1));
         got.delete();
         channelLoad();
         checkOutput("ch_after_err", VW'(got.size()), VW'(4));
      end else begin
         checkOutput("early_data_fwd", VW'(got.size()), VW'(1));
         if (got.size() >= 1) checkOutput("early_data_flag", VW'(got[0][VW]), VW'(0));
         checkOutput("early_data_noerr", VW'(o_err), VW'(0));
      end

      // Kind switch mid-vector, then reset and a fresh vector.
      doReset(1);
      sendElem(1'b1, 32'hD000_0001, 1'b1);
      sendElem(1'b1, 32'hD000_0002, 1'b1);
      sendElem(1'b0, 32'hD000_0003, 1'b1);
      checkOutput("switch_err", VW'(o_err), VW'(CHECK_EN));
      doReset(1);
      got.delete();
      for (int k = 0; k < 4; k++) sendElem(1'b1, 32'hE000_0000 + 32'(k), 1'b1);
      idle(2, 1'b1);
      checkOutput("fresh_count", VW'(got.size()), VW'(1));
      if (got.size() >= 1)
         checkOutput("fresh_vec", got[0][VW-1:0], 128'hE000_0000_E000_0001_E000_0002_E000_0003);
      checkOutput("fresh_err", VW'(o_err), VW'(0));

      // Random traffic with occasional kind flips, stalls and resets.
      kind_r = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         if (m_part.size() == 0) kind_r = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 199) == 0) begin
            applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, acc_r);
         end else begin
            applyStimulus(1'b0, $urandom_range(0, 3) != 0,
                          ($urandom_range(0, 19) == 0) ? !kind_r : kind_r,
                          $urandom, $urandom_range(0, 2) != 0, acc_r);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
